// File: rtl/systolic_feed_ctrl_if.sv
// Signal bundle between the host/load logic, systolic_feed_ctrl and the MAC array edges.
// master = host side (writes, start); slave = the feed controller.
interface systolic_feed_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned A_ROWS     = 2,
    parameter int unsigned A_COLS     = 2,
    parameter int unsigned B_COLS     = 2
);
    localparam int unsigned MaxRc  = (A_ROWS > A_COLS) ? A_ROWS : A_COLS;
    localparam int unsigned MaxDim = (MaxRc > B_COLS) ? MaxRc : B_COLS;
    localparam int unsigned IDX_W  = $clog2((MaxDim > 2) ? MaxDim : 2);

    logic                                 wr_en;
    logic                                 wr_sel;
    logic [IDX_W-1:0]                     wr_row;
    logic [IDX_W-1:0]                     wr_col;
    logic [DATA_WIDTH-1:0]                wr_data;
    logic                                 start;
    logic                                 busy;
    logic                                 done;
    logic                                 array_clr;
    logic [A_ROWS-1:0][DATA_WIDTH-1:0]    a_out;
    logic [B_COLS-1:0][DATA_WIDTH-1:0]    b_out;

    modport master (
        output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
        input  busy, done, array_clr, a_out, b_out
    );

    modport slave (
        input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
        output busy, done, array_clr, a_out, b_out
    );
endinterface

// File: rtl/systolic_feed_ctrl.sv
// Operand buffers and sequencer for an output-stationary systolic MAC array:
// clear accumulators, stream A/B diagonally skewed, drain the MAC pipeline, pulse done.
module systolic_feed_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned A_ROWS     = 2,
    parameter int unsigned A_COLS     = 2,
    parameter int unsigned B_COLS     = 2,
    parameter int unsigned MAC_LAT    = 1
) (
    input logic                 clk,
    input logic                 reset,
    systolic_feed_ctrl_if.slave bus
);
    localparam int unsigned MaxRc     = (A_ROWS > A_COLS) ? A_ROWS : A_COLS;
    localparam int unsigned MaxDim    = (MaxRc > B_COLS) ? MaxRc : B_COLS;
    localparam int unsigned IdxW      = $clog2((MaxDim > 2) ? MaxDim : 2);
    localparam int unsigned StreamLen = A_ROWS + A_COLS + B_COLS - 2;
    localparam int unsigned CntMax    = (StreamLen > MAC_LAT) ? StreamLen : MAC_LAT;
    localparam int unsigned CntW      = $clog2(CntMax + 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StStream,
        StDrain,
        StDone
    } state_e;

    state_e                                         state_q, state_d;
    logic [CntW-1:0]                                cnt_q, cnt_d;
    logic [A_ROWS-1:0][A_COLS-1:0][DATA_WIDTH-1:0]  a_buf_q, a_buf_d;
    logic [A_COLS-1:0][B_COLS-1:0][DATA_WIDTH-1:0]  b_buf_q, b_buf_d;
    logic [A_ROWS-1:0][DATA_WIDTH-1:0]              a_out_q, a_out_d;
    logic [B_COLS-1:0][DATA_WIDTH-1:0]              b_out_q, b_out_d;
    logic [CntW-1:0]                                feed_t;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                state_d = StStream;
                cnt_d   = '0;
            end
            StStream: begin
                if (cnt_q == CntW'(StreamLen - 1)) begin
                    cnt_d   = '0;
                    state_d = (MAC_LAT == 0) ? StDone : StDrain;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDrain: begin
                if (cnt_q == CntW'(MAC_LAT - 1)) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered, so load the skew slot for the cycle being entered.
    always_comb begin
        feed_t  = (state_q == StClear) ? '0 : cnt_q + 1'b1;
        a_out_d = '0;
        b_out_d = '0;
        if (state_d == StStream) begin
            for (int i = 0; i < int'(A_ROWS); i++) begin
                for (int k = 0; k < int'(A_COLS); k++) begin
                    if (int'(feed_t) == i + k) begin
                        a_out_d[i] = a_buf_q[i][k];
                    end
                end
            end
            for (int j = 0; j < int'(B_COLS); j++) begin
                for (int k = 0; k < int'(A_COLS); k++) begin
                    if (int'(feed_t) == j + k) begin
                        b_out_d[j] = b_buf_q[k][j];
                    end
                end
            end
        end
    end

    // Out-of-range indices never match a loop position, so they fall through unwritten.
    always_comb begin
        a_buf_d = a_buf_q;
        b_buf_d = b_buf_q;
        if (bus.wr_en && (state_q == StIdle)) begin
            if (!bus.wr_sel) begin
                for (int i = 0; i < int'(A_ROWS); i++) begin
                    for (int k = 0; k < int'(A_COLS); k++) begin
                        if ((bus.wr_row == IdxW'(i)) && (bus.wr_col == IdxW'(k))) begin
                            a_buf_d[i][k] = bus.wr_data;
                        end
                    end
                end
            end else begin
                for (int k = 0; k < int'(A_COLS); k++) begin
                    for (int j = 0; j < int'(B_COLS); j++) begin
                        if ((bus.wr_row == IdxW'(k)) && (bus.wr_col == IdxW'(j))) begin
                            b_buf_d[k][j] = bus.wr_data;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_buf_q <= '0;
            b_buf_q <= '0;
            a_out_q <= '0;
            b_out_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_buf_q <= a_buf_d;
            b_buf_q <= b_buf_d;
            a_out_q <= a_out_d;
            b_out_q <= b_out_d;
        end
    end

    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = (state_q == StDone);
    assign bus.array_clr = (state_q == StClear);
    assign bus.a_out     = a_out_q;
    assign bus.b_out     = b_out_q;

    done_single_pulse_a: assert property (@(posedge clk) disable iff (reset)
        bus.done |=> !bus.done);

    clear_quiet_a: assert property (@(posedge clk) disable iff (reset)
        bus.array_clr |-> ((a_out_q == '0) && (b_out_q == '0)));
endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Scoreboard bench: two controllers (2x2x2 and 3x4x2); stimulus pushes expected runs,
// per-DUT monitors pop them and check stream skew, timing, and the resulting array product.
module tb_systolic_feed_ctrl;
    localparam int unsigned LAT = 1;

    typedef struct packed {
        logic [3:0][3:0][7:0] a;
        logic [3:0][3:0][7:0] b;
        logic [31:0]          start_edge;
    } run_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int nr [2] = '{2, 3};
    int nk [2] = '{2, 4};
    int nc [2] = '{2, 2};

    logic       drv_rst     [2];
    logic       drv_wr_en   [2];
    logic       drv_wr_sel  [2];
    logic       drv_start   [2];
    logic [1:0] drv_wr_row  [2];
    logic [1:0] drv_wr_col  [2];
    logic [7:0] drv_wr_data [2];

    logic            busy_o [2];
    logic            done_o [2];
    logic            clr_o  [2];
    logic [3:0][7:0] a_obs  [2];
    logic [3:0][7:0] b_obs  [2];

    logic [3:0][3:0][7:0] mdl_a [2];
    logic [3:0][3:0][7:0] mdl_b [2];
    run_t q0[$];
    run_t q1[$];
    bit   mon_busy [2] = '{1'b0, 1'b0};
    int   n_checks = 0;
    int   n_errors = 0;

    systolic_feed_ctrl_if #(.DATA_WIDTH(8), .A_ROWS(2), .A_COLS(2), .B_COLS(2)) bus0 ();
    systolic_feed_ctrl_if #(.DATA_WIDTH(8), .A_ROWS(3), .A_COLS(4), .B_COLS(2)) bus1 ();

    assign bus0.wr_en   = drv_wr_en[0];
    assign bus0.wr_sel  = drv_wr_sel[0];
    assign bus0.wr_row  = drv_wr_row[0][0];
    assign bus0.wr_col  = drv_wr_col[0][0];
    assign bus0.wr_data = drv_wr_data[0];
    assign bus0.start   = drv_start[0];
    assign bus1.wr_en   = drv_wr_en[1];
    assign bus1.wr_sel  = drv_wr_sel[1];
    assign bus1.wr_row  = drv_wr_row[1];
    assign bus1.wr_col  = drv_wr_col[1];
    assign bus1.wr_data = drv_wr_data[1];
    assign bus1.start   = drv_start[1];

    assign busy_o[0] = bus0.busy;
    assign done_o[0] = bus0.done;
    assign clr_o[0]  = bus0.array_clr;
    assign a_obs[0]  = 32'(bus0.a_out);
    assign b_obs[0]  = 32'(bus0.b_out);
    assign busy_o[1] = bus1.busy;
    assign done_o[1] = bus1.done;
    assign clr_o[1]  = bus1.array_clr;
    assign a_obs[1]  = 32'(bus1.a_out);
    assign b_obs[1]  = 32'(bus1.b_out);

    systolic_feed_ctrl #(
        .DATA_WIDTH(8), .A_ROWS(2), .A_COLS(2), .B_COLS(2), .MAC_LAT(LAT)
    ) u_dut0 (
        .clk  (clk),
        .reset(drv_rst[0]),
        .bus  (bus0)
    );

    systolic_feed_ctrl #(
        .DATA_WIDTH(8), .A_ROWS(3), .A_COLS(4), .B_COLS(2), .MAC_LAT(LAT)
    ) u_dut1 (
        .clk  (clk),
        .reset(drv_rst[1]),
        .bus  (bus1)
    );

    task automatic chk(input string name, input int sel, input logic [127:0] act,
                       input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d: got %0h, expected %0h", name, sel, act, exp);
        end
    endtask

    function automatic int qsize(input int sel);
        return (sel == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [127:0] all_outs(input int sel);
        return 128'({busy_o[sel], clr_o[sel], done_o[sel], a_obs[sel], b_obs[sel]});
    endfunction

    // One host cycle; when accepted, the model applies the write first, then snapshots for start.
    task automatic drive(input int sel, input bit do_wr, input bit m, input int r, input int c,
                         input logic [7:0] v, input bit do_start, input bit accept);
        run_t rec;
        @(negedge clk);
        drv_wr_en[sel]   = do_wr;
        drv_wr_sel[sel]  = m;
        drv_wr_row[sel]  = 2'(r);
        drv_wr_col[sel]  = 2'(c);
        drv_wr_data[sel] = v;
        drv_start[sel]   = do_start;
        if (accept && do_wr) begin
            if (!m && r < nr[sel] && c < nk[sel]) mdl_a[sel][r][c] = v;
            if (m && r < nk[sel] && c < nc[sel]) mdl_b[sel][r][c] = v;
        end
        if (accept && do_start) begin
            rec.a          = mdl_a[sel];
            rec.b          = mdl_b[sel];
            rec.start_edge = 32'(edge_cnt + 1);
            if (sel == 0) q0.push_back(rec);
            else q1.push_back(rec);
        end
        @(posedge clk);
        #1;
        drv_wr_en[sel] = 1'b0;
        drv_start[sel] = 1'b0;
    endtask

    task automatic wr(input int sel, input bit m, input int r, input int c, input logic [7:0] v);
        drive(sel, 1'b1, m, r, c, v, 1'b0, 1'b1);
    endtask

    task automatic go(input int sel);
        drive(sel, 1'b0, 1'b0, 0, 0, 8'h00, 1'b1, 1'b1);
    endtask

    task automatic wait_idle(input int sel);
        int n = 0;
        while ((qsize(sel) != 0 || mon_busy[sel]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("run_completes", sel, 128'(qsize(sel) == 0 && !mon_busy[sel]), 128'(1));
    endtask

    task automatic do_reset(input int sel);
        drv_rst[sel] = 1'b1;
        mdl_a[sel]   = '0;
        mdl_b[sel]   = '0;
        repeat (2) @(negedge clk);
        drv_rst[sel] = 1'b0;
    endtask

    task automatic monitor(input int sel);
        run_t                 rec;
        int                   s_len;
        bit                   aborted;
        logic [15:0][3:0][7:0] ha, hb;
        logic [3:0][7:0]      ea, eb;
        logic [15:0]          acc, ref_c;
        s_len = nr[sel] + nk[sel] + nc[sel] - 2;
        forever begin
            @(negedge clk);
            if (drv_rst[sel]) continue;
            if (!clr_o[sel]) begin
                chk("idle_quiet", sel, all_outs(sel), 128'(0));
                continue;
            end
            mon_busy[sel] = 1'b1;
            chk("clear_expected", sel, 128'(qsize(sel) != 0), 128'(1));
            if (qsize(sel) == 0) begin
                mon_busy[sel] = 1'b0;
                continue;
            end
            if (sel == 0) rec = q0.pop_front();
            else rec = q1.pop_front();
            chk("clear_timing", sel, 128'(edge_cnt), 128'(rec.start_edge));
            chk("clear_outputs", sel, all_outs(sel), {62'd0, 3'b110, 64'd0});
            aborted = 1'b0;
            ha = '0;
            hb = '0;
            for (int t = 0; t < s_len; t++) begin
                @(negedge clk);
                if (drv_rst[sel]) begin
                    chk("reset_outputs", sel, all_outs(sel), 128'(0));
                    aborted = 1'b1;
                    break;
                end
                ea = '0;
                eb = '0;
                for (int i = 0; i < nr[sel]; i++)
                    if (t - i >= 0 && t - i < nk[sel]) ea[i] = rec.a[i][t - i];
                for (int j = 0; j < nc[sel]; j++)
                    if (t - j >= 0 && t - j < nk[sel]) eb[j] = rec.b[t - j][j];
                chk("stream_a", sel, 128'(a_obs[sel]), 128'(ea));
                chk("stream_b", sel, 128'(b_obs[sel]), 128'(eb));
                chk("stream_flags", sel, 128'({busy_o[sel], clr_o[sel], done_o[sel]}),
                    128'(3'b100));
                ha[t] = a_obs[sel];
                hb[t] = b_obs[sel];
            end
            for (int l = 0; l < int'(LAT) && !aborted; l++) begin
                @(negedge clk);
                if (drv_rst[sel]) begin
                    chk("reset_outputs", sel, all_outs(sel), 128'(0));
                    aborted = 1'b1;
                end else begin
                    chk("drain_outputs", sel, all_outs(sel), {62'd0, 3'b100, 64'd0});
                end
            end
            if (!aborted) begin
                @(negedge clk);
                if (drv_rst[sel]) begin
                    chk("reset_outputs", sel, all_outs(sel), 128'(0));
                end else begin
                    chk("done_pulse", sel, all_outs(sel), {62'd0, 3'b101, 64'd0});
                    // PE(i,j) sees row-i data delayed by j and column-j data delayed by i.
                    for (int i = 0; i < nr[sel]; i++) begin
                        for (int j = 0; j < nc[sel]; j++) begin
                            acc   = '0;
                            ref_c = '0;
                            for (int tau = 0; tau < s_len + 4; tau++) begin
                                if (tau - j >= 0 && tau - j < s_len &&
                                    tau - i >= 0 && tau - i < s_len)
                                    acc = acc + 16'(ha[tau - j][i]) * 16'(hb[tau - i][j]);
                            end
                            for (int k = 0; k < nk[sel]; k++)
                                ref_c = ref_c + 16'(rec.a[i][k]) * 16'(rec.b[k][j]);
                            chk("c_result", sel, 128'(acc), 128'(ref_c));
                        end
                    end
                end
            end
            mon_busy[sel] = 1'b0;
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            drv_rst[s]     = 1'b1;
            drv_wr_en[s]   = 1'b0;
            drv_wr_sel[s]  = 1'b0;
            drv_wr_row[s]  = '0;
            drv_wr_col[s]  = '0;
            drv_wr_data[s] = '0;
            drv_start[s]   = 1'b0;
            mdl_a[s]       = '0;
            mdl_b[s]       = '0;
        end
        repeat (2) @(negedge clk);
        chk("reset_state", 0, all_outs(0), 128'(0));
        chk("reset_state", 1, all_outs(1), 128'(0));
        drv_rst[0] = 1'b0;
        drv_rst[1] = 1'b0;

        // A=[[1,2],[3,4]], B=[[5,6],[7,8]]
        wr(0, 0, 0, 0, 8'd1); wr(0, 0, 0, 1, 8'd2); wr(0, 0, 1, 0, 8'd3); wr(0, 0, 1, 1, 8'd4);
        wr(0, 1, 0, 0, 8'd5); wr(0, 1, 0, 1, 8'd6); wr(0, 1, 1, 0, 8'd7); wr(0, 1, 1, 1, 8'd8);
        go(0);
        wait_idle(0);

        // B = identity, rerun
        wr(0, 1, 0, 0, 8'd1); wr(0, 1, 0, 1, 8'd0); wr(0, 1, 1, 0, 8'd0); wr(0, 1, 1, 1, 8'd1);
        go(0);
        wait_idle(0);

        // start pulses and writes while busy must be ignored
        go(0);
        for (int k = 0; k < 5; k++) drive(0, 1'b1, bit'(k % 2), 0, 0, 8'hEE, 1'b1, 1'b0);
        wait_idle(0);
        go(0);
        wait_idle(0);

        // reset in STREAM t=2
        go(0);
        repeat (3) @(posedge clk);
        #1;
        do_reset(0);
        go(0);
        wait_idle(0);

        // write and start in the same cycle
        wr(0, 0, 0, 1, 8'd2); wr(0, 0, 1, 0, 8'd3); wr(0, 0, 1, 1, 8'd4);
        wr(0, 1, 0, 0, 8'd5); wr(0, 1, 0, 1, 8'd6); wr(0, 1, 1, 0, 8'd7); wr(0, 1, 1, 1, 8'd8);
        drive(0, 1'b1, 1'b0, 0, 0, 8'd9, 1'b1, 1'b1);
        wait_idle(0);

        // 3x4x2 random runs; row 3 of A and cols 2..3 of B are out of range
        for (int run = 0; run < 3; run++) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    wr(1, 1'b0, r, c, ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
                    wr(1, 1'b1, r, c, ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
                end
            end
            go(1);
            wait_idle(1);
        end
        go(1);
        wait_idle(1);

        repeat (3) @(negedge clk);
        chk("queues_drained", 0, 128'(q0.size() + q1.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
